// File: rtl/acs_unit_k3.sv
// rtl/acs_unit_k3.sv - Add-compare-select stage for the rate-1/2, K=3 Viterbi decoder
//
// Each accepted symbol adds the branch metrics from the BMC stage to the stored
// path metrics, picks one survivor per next state and updates the metric
// registers. It also emits one decision word toward traceback.
//
// Optional feature: ACS_NORM_EN. When defined, all four metrics drop by half
// range once the smallest of them reaches 2^(PM_W-1). When undefined, metrics
// simply saturate and norm_pulse stays 0.
//
// Ports:
//   clk, rst_n   clock, synchronous active-low reset
//   bm_valid     branch metrics valid
//   bm_ready     stage can take branch metrics (!dec_valid | dec_ready)
//   bm_start     first symbol of a frame, qualified by bm_valid
//   bm_in        bm[ns][j] at [(ns*2+j)*BM_W +: BM_W]
//   dec_valid    decision word valid
//   dec_ready    traceback accepts the decision word
//   dec_bits     bit ns = chosen predecessor branch j of state ns
//   dec_last     decision word belongs to the last symbol of the frame
//   best_state   lowest-index state holding the minimum new metric
//   pm_out       path metrics, state s at [s*PM_W +: PM_W]
//   norm_pulse   normalization applied to this decision word
module acs_unit_k3 #(
    parameter int PM_W      = 8,
    parameter int BM_W      = 2,
    parameter int INIT_BIAS = 32,
    parameter int FRAME_LEN = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              bm_valid,
    output logic              bm_ready,
    input  logic              bm_start,
    input  logic [8*BM_W-1:0] bm_in,
    output logic              dec_valid,
    input  logic              dec_ready,
    output logic [3:0]        dec_bits,
    output logic              dec_last,
    output logic [1:0]        best_state,
    output logic [4*PM_W-1:0] pm_out,
    output logic              norm_pulse
);

    localparam int CNT_W = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
    localparam logic [PM_W-1:0]  PM_MAX   = {PM_W{1'b1}};
    localparam logic [PM_W-1:0]  PM_HALF  = {1'b1, {(PM_W-1){1'b0}}};
    localparam logic [PM_W-1:0]  PM_BIAS  = PM_W'(INIT_BIAS);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FRAME_LEN - 1);

    logic [PM_W-1:0]  pm_q   [4];
    logic [PM_W-1:0]  src_pm [4];
    logic [PM_W-1:0]  sel_pm [4];
    logic [PM_W-1:0]  new_pm [4];
    logic [PM_W:0]    cand0  [4];
    logic [PM_W:0]    cand1  [4];
    logic [3:0]       sel_bits;
    logic [PM_W-1:0]  min01, min23, min_pm;
    logic             pick1, pick3, pick_hi;
    logic [1:0]       best;
    logic             norm;
    logic [CNT_W-1:0] cnt_q, cur_cnt;
    logic             is_last;
    logic             accept;

    assign bm_ready = !dec_valid || dec_ready;
    assign accept   = bm_valid && bm_ready;

    // A frame start substitutes the init vector for the stored metrics
    assign src_pm[0] = bm_start ? '0      : pm_q[0];
    assign src_pm[1] = bm_start ? PM_BIAS : pm_q[1];
    assign src_pm[2] = bm_start ? PM_BIAS : pm_q[2];
    assign src_pm[3] = bm_start ? PM_BIAS : pm_q[3];

    for (genvar ns = 0; ns < 4; ns++) begin : g_state
        // Predecessors of next state ns are {ns[0], j}
        localparam int P0 = (ns % 2) * 2;
        localparam int P1 = P0 + 1;

        // One extra bit so the compare sees the true sum before saturation
        assign cand0[ns] = {1'b0, src_pm[P0]}
                         + {{(PM_W+1-BM_W){1'b0}}, bm_in[(ns*2)*BM_W +: BM_W]};
        assign cand1[ns] = {1'b0, src_pm[P1]}
                         + {{(PM_W+1-BM_W){1'b0}}, bm_in[(ns*2+1)*BM_W +: BM_W]};

        // Strict compare: a tie keeps branch 0
        assign sel_bits[ns] = cand1[ns] < cand0[ns];

        always_comb begin
            sel_pm[ns] = sel_bits[ns] ? cand1[ns][PM_W-1:0] : cand0[ns][PM_W-1:0];
            if (sel_bits[ns] ? cand1[ns][PM_W] : cand0[ns][PM_W])
                sel_pm[ns] = PM_MAX;
        end

        assign new_pm[ns] = norm ? (sel_pm[ns] - PM_HALF) : sel_pm[ns];
    end

    // Minimum search; strict compares give the lowest index on ties. The
    // normalization shift is uniform, so ordering on sel_pm equals new_pm.
    assign pick1   = sel_pm[1] < sel_pm[0];
    assign min01   = pick1 ? sel_pm[1] : sel_pm[0];
    assign pick3   = sel_pm[3] < sel_pm[2];
    assign min23   = pick3 ? sel_pm[3] : sel_pm[2];
    assign pick_hi = min23 < min01;
    assign min_pm  = pick_hi ? min23 : min01;
    assign best    = pick_hi ? {1'b1, pick3} : {1'b0, pick1};

`ifdef ACS_NORM_EN
    assign norm = min_pm >= PM_HALF;
`else
    assign norm = 1'b0;
`endif

    assign cur_cnt = bm_start ? '0 : cnt_q;
    assign is_last = cur_cnt == CNT_LAST;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pm_q[0]    <= '0;
            pm_q[1]    <= PM_BIAS;
            pm_q[2]    <= PM_BIAS;
            pm_q[3]    <= PM_BIAS;
            dec_valid  <= 1'b0;
            dec_bits   <= '0;
            dec_last   <= 1'b0;
            best_state <= '0;
            norm_pulse <= 1'b0;
            cnt_q      <= '0;
        end else if (accept) begin
            pm_q[0]    <= new_pm[0];
            pm_q[1]    <= new_pm[1];
            pm_q[2]    <= new_pm[2];
            pm_q[3]    <= new_pm[3];
            dec_valid  <= 1'b1;
            dec_bits   <= sel_bits;
            dec_last   <= is_last;
            best_state <= best;
            norm_pulse <= norm;
            cnt_q      <= is_last ? '0 : cur_cnt + CNT_W'(1);
        end else if (dec_ready) begin
            dec_valid  <= 1'b0;
        end
    end

    assign pm_out = {pm_q[3], pm_q[2], pm_q[1], pm_q[0]};

endmodule

// File: tb/tb_acs_unit_k3.sv
// tb/tb_acs_unit_k3.sv - Directed self-checking bench for acs_unit_k3
module tb_acs_unit_k3;

    logic        clk;
    logic        rst_n;
    logic        bm_valid;
    logic        bm_ready;
    logic        bm_start;
    logic [15:0] bm_in;
    logic        dec_valid;
    logic        dec_ready;
    logic [3:0]  dec_bits;
    logic        dec_last;
    logic [1:0]  best_state;
    logic [31:0] pm_out;
    logic        norm_pulse;

    int n_vec = 0;
    int n_err = 0;

    acs_unit_k3 #(
        .PM_W(8), .BM_W(2), .INIT_BIAS(32), .FRAME_LEN(4)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .bm_valid(bm_valid), .bm_ready(bm_ready), .bm_start(bm_start),
        .bm_in(bm_in),
        .dec_valid(dec_valid), .dec_ready(dec_ready),
        .dec_bits(dec_bits), .dec_last(dec_last), .best_state(best_state),
        .pm_out(pm_out), .norm_pulse(norm_pulse)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Arguments in order bm[0][0], bm[0][1], bm[1][0], ... bm[3][1]
    function automatic logic [15:0] bmv(input logic [1:0] b00, b01, b10, b11,
                                        input logic [1:0] b20, b21, b30, b31);
        return {b31, b30, b21, b20, b11, b10, b01, b00};
    endfunction

    function automatic logic [31:0] pmv(input int s3, s2, s1, s0);
        return {8'(s3), 8'(s2), 8'(s1), 8'(s0)};
    endfunction

    task automatic sym(input logic start, input logic [15:0] bm);
        bm_valid = 1'b1;
        bm_start = start;
        bm_in    = bm;
        @(posedge clk); #1;
        bm_valid = 1'b0;
        bm_start = 1'b0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    int v;
    logic exp_np;

    initial begin
        rst_n = 1'b1; bm_valid = 1'b0; bm_start = 1'b0; bm_in = '0; dec_ready = 1'b1;
        @(posedge clk); #1;
        do_reset();

        // Reset state
        check("rst_valid", dec_valid, 0);
        check("rst_ready", bm_ready, 1);
        check("rst_pm", pm_out, pmv(32, 32, 32, 0));
        check("rst_bits", dec_bits, 0);
        check("rst_best", best_state, 0);
        check("rst_norm", norm_pulse, 0);

        // Frame start, all branch metrics zero
        sym(1'b1, '0);
        check("s1_valid", dec_valid, 1);
        check("s1_bits", dec_bits, 4'b0000);
        check("s1_pm", pm_out, pmv(32, 0, 32, 0));
        check("s1_best", best_state, 0);
        check("s1_last", dec_last, 0);

        // Continuation: state 1 predecessors are 2 (pm 0) and 3 (pm 32)
        sym(1'b0, bmv(0, 0, 2, 1, 0, 0, 0, 0));
        check("s2_bits", dec_bits, 4'b0000);
        check("s2_pm", pm_out, pmv(0, 0, 2, 0));

        // Same metrics from the init vector: state 1 takes branch 1 (33 < 34)
        sym(1'b1, bmv(0, 0, 2, 1, 0, 0, 0, 0));
        check("s3_bits", dec_bits, 4'b0010);
        check("s3_pm", pm_out, pmv(32, 0, 33, 0));
        check("s3_best", best_state, 0);
        check("s3_last", dec_last, 0);

        // Penalize state 0 so state 1 becomes the lowest-index minimum
        sym(1'b0, bmv(3, 3, 0, 0, 0, 0, 0, 0));
        check("s4_pm", pm_out, pmv(0, 0, 0, 3));
        check("s4_best", best_state, 1);
        check("s4_bits", dec_bits, 4'b0000);

        // Branch 1 wins for states 0 and 2
        sym(1'b0, bmv(0, 0, 0, 0, 1, 0, 0, 0));
        check("s5_bits", dec_bits, 4'b0101);
        check("s5_pm", pm_out, pmv(0, 0, 0, 0));
        check("s5_last", dec_last, 0);

        sym(1'b0, '0);
        check("s6_last", dec_last, 1);
        sym(1'b0, '0);
        check("s7_last_wrap", dec_last, 0);

        // Backpressure: three stalled cycles with bm_valid high
        bm_valid = 1'b1; bm_start = 1'b0; bm_in = bmv(0, 0, 0, 0, 0, 0, 2, 1);
        dec_ready = 1'b0;
        #1;
        check("bp_ready", bm_ready, 0);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            check("bp_valid", dec_valid, 1);
            check("bp_pm_hold", pm_out, pmv(0, 0, 0, 0));
            check("bp_bits_hold", dec_bits, 4'b0000);
            check("bp_ready_lo", bm_ready, 0);
        end
        dec_ready = 1'b1;
        #1;
        check("bp_ready_hi", bm_ready, 1);
        @(posedge clk); #1;
        bm_valid = 1'b0;
        check("bp_acc_pm", pm_out, pmv(1, 0, 0, 0));
        check("bp_acc_bits", dec_bits, 4'b1000);
        check("bp_acc_valid", dec_valid, 1);
        check("bp_acc_last", dec_last, 0);
        @(posedge clk); #1;
        check("drain_valid", dec_valid, 0);
        check("drain_pm_hold", pm_out, pmv(1, 0, 0, 0));

        // Mid-frame restart on the second symbol
        sym(1'b1, '0);
        sym(1'b1, '0);
        check("rs_pm", pm_out, pmv(32, 0, 32, 0));
        check("rs_last0", dec_last, 0);
        sym(1'b0, '0);
        check("rs_last1", dec_last, 0);
        sym(1'b0, '0);
        check("rs_last2", dec_last, 0);
        sym(1'b0, '0);
        check("rs_last3", dec_last, 1);

        // Reset while a decision word is pending
        sym(1'b0, bmv(1, 1, 1, 1, 1, 1, 1, 1));
        dec_ready = 1'b0;
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        dec_ready = 1'b1;
        check("mr_valid", dec_valid, 0);
        check("mr_pm", pm_out, pmv(32, 32, 32, 0));
        check("mr_bits", dec_bits, 0);
        sym(1'b0, '0);
        check("mr_pm1", pm_out, pmv(32, 0, 32, 0));
        check("mr_last0", dec_last, 0);
        sym(1'b0, '0);
        sym(1'b0, '0);
        check("mr_last2", dec_last, 0);
        sym(1'b0, '0);
        check("mr_last3", dec_last, 1);

        // Long run of maximal branch metrics
        sym(1'b1, bmv(3, 3, 3, 3, 3, 3, 3, 3));
        check("sat_first", pm_out, pmv(35, 3, 35, 3));
        v = 3;
        for (int n = 2; n <= 100; n++) begin
            sym(1'b0, bmv(3, 3, 3, 3, 3, 3, 3, 3));
            v = v + 3;
            if (v > 255) v = 255;
            exp_np = 1'b0;
`ifdef ACS_NORM_EN
            if (v >= 128) begin
                v = v - 128;
                exp_np = 1'b1;
            end
`endif
            check("sat_pm", pm_out, pmv(v, v, v, v));
            check("sat_norm", norm_pulse, exp_np);
        end
        check("sat_bits", dec_bits, 4'b0000);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
